// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory end of the shared instruction/data port.
// Accepts one request at a time, inserts LATENCY wait states, then completes
// with a single-cycle ready pulse. Misaligned or out-of-range accesses still
// complete, but they are flagged on o_err and leave the array untouched.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  LAST_CNT   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_we;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic         r_err;
  logic         r_ready;
  logic [31:0]  r_rdata;
  logic [31:0]  r_mem [DEPTH];

  logic         w_live;
  logic         w_we;
  logic [31:0]  w_addr;
  logic [31:0]  w_wdata;
  logic         w_err;
  logic [AW-1:0] w_idx;
  logic         w_commit;

  // With zero wait states the access commits on the acceptance edge, so the
  // live inputs are used in IDLE; otherwise the captured copy is used, which
  // keeps the request intact even if the requester misbehaves during WAIT.
  assign w_live  = (r_state == S_IDLE);
  assign w_we    = w_live ? i_we    : r_we;
  assign w_addr  = w_live ? i_addr  : r_addr;
  assign w_wdata = w_live ? i_wdata : r_wdata;
  assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIMIT);
  assign w_idx   = w_addr[AW+1:2];

  // Edge that enters RESP: this is where the array is read or written.
  assign w_commit = ((r_state == S_IDLE) && i_req && (LATENCY == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == LAST_CNT));

  // Control FSM, request capture, registered response and the storage array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      r_ready <= w_commit;
      r_err   <= w_commit ? w_err : 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_cnt   <= 4'd0;
            r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_commit) begin
        if (!w_we) begin
          r_rdata <= w_err ? 32'd0 : r_mem[w_idx];
        end else if (!w_err) begin
          r_mem[w_idx] <= w_wdata;
        end
      end
    end
  end

  assign o_ready = r_ready;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LATENCY 2, 0, 15) with a
// behavioural memory model; directed scenarios followed by random traffic.
module tb_mem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        req   [NDUT];
  logic        we    [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic [31:0] rdata [NDUT];
  logic        ready [NDUT];
  logic        err   [NDUT];

  int lat_tab [NDUT] = '{2, 0, 15};

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 0 : 15);
      mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req[gi]),
        .i_we    (we[gi]),
        .i_addr  (addr[gi]),
        .i_wdata (wdata[gi]),
        .o_rdata (rdata[gi]),
        .o_ready (ready[gi]),
        .o_err   (err[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: contents of each memory and the last read response.
  logic [31:0] model_mem [NDUT][DEPTH];
  logic [31:0] model_rd  [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called mid-cycle: outputs must clear at once, memories are wiped.
  task automatic apply_reset();
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_eq("rst_ready", 32'(ready[d]), 32'd0);
      check_eq("rst_err", 32'(err[d]), 32'd0);
      check_eq("rst_rdata", rdata[d], 32'd0);
      model_rd[d] = 32'd0;
      for (int i = 0; i < DEPTH; i++) model_mem[d][i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One access starting in IDLE; drop_early scrambles the inputs during WAIT.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input bit drop_early);
    int          n;
    logic        exp_err;
    logic [5:0]  idx;
    exp_err = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    idx = a[7:2];
    if (!w) model_rd[d] = exp_err ? 32'd0 : model_mem[d][idx];
    else if (!exp_err) model_mem[d][idx] = wd;

    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (drop_early && n == 1 && !ready[d]) begin
        req[d] = 1'b0; we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd;
      end
    end while (!ready[d] && n < 40);
    req[d] = 1'b0;

    check_eq("latency", 32'(n), 32'(lat_tab[d] + 1));
    check_eq("err", 32'(err[d]), 32'(exp_err));
    check_eq("rdata", rdata[d], model_rd[d]);
    $display("txn dut%0d lat=%0d we=%0b addr=0x%08h wdata=0x%08h -> cycles=%0d rdata=0x%08h err=%0b",
             d, lat_tab[d], w, a, wd, n, rdata[d], err[d]);
    @(posedge clk);
    #1;
    check_eq("single_pulse", 32'(ready[d]), 32'd0);
    check_eq("err_idle", 32'(err[d]), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    int last;
    logic [31:0] a;

    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end

    // Reset asserted mid-cycle, then idle
    @(posedge clk);
    #3;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_ready", 32'(ready[0]), 32'd0);
    end

    // Write then read
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h14, 32'h0, 1'b0);

    // Back-to-back reads with req held high
    xact(0, 1'b1, 32'h0, 32'd1, 1'b0);
    xact(0, 1'b1, 32'h4, 32'd2, 1'b0);
    xact(0, 1'b1, 32'h8, 32'd3, 1'b0);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
    n = 0; k = 0; last = 0;
    while (k < 3 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (ready[0]) begin
        if (k == 0) check_eq("b2b_first", 32'(n), 32'd3);
        else        check_eq("b2b_gap", 32'(n - last), 32'd4);
        check_eq("b2b_rdata", rdata[0], 32'(k + 1));
        $display("txn dut0 b2b read addr=0x%08h -> cycle=%0d rdata=0x%08h", 32'(k * 4), n, rdata[0]);
        last = n;
        k++;
        addr[0] = 32'(k * 4);
      end
    end
    req[0] = 1'b0;
    check_eq("b2b_count", 32'(k), 32'd3);
    model_rd[0] = 32'd3;
    @(posedge clk);
    #1;
    check_eq("b2b_single", 32'(ready[0]), 32'd0);

    // Error cases: misaligned write aliases word 0 but must not land there
    xact(0, 1'b1, 32'h102, 32'hBAD0BAD0, 1'b0);
    xact(0, 1'b0, 32'h100, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset during WAIT aborts a pending write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
    @(posedge clk);
    #1;
    check_eq("abort_no_ready", 32'(ready[0]), 32'd0);
    #2;
    apply_reset();
    check_eq("abort_after_ready", 32'(ready[0]), 32'd0);
    xact(0, 1'b0, 32'h20, 32'h0, 1'b0);

    // LATENCY 0 and 15 instances
    xact(1, 1'b1, 32'h4, 32'h0000_0404, 1'b0);
    xact(1, 1'b0, 32'h4, 32'h0, 1'b0);
    xact(2, 1'b1, 32'h4, 32'h1515_1515, 1'b0);
    xact(2, 1'b0, 32'h4, 32'h0, 1'b0);
    xact(2, 1'b0, 32'h4, 32'h0, 1'b1);
    xact(2, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b1);
    xact(2, 1'b0, 32'h8, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_eq("drop_no_extra", 32'(ready[2]), 32'd0);
    end

    // Random traffic on every instance
    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 25; t++) begin
        case ($urandom_range(0, 5))
          0:       a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
          1:       a = 32'h100 + 32'($urandom_range(0, 255));
          default: a = 32'($urandom_range(0, 63) * 4);
        endcase
        xact(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 3) == 0));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
